// File: rtl/boot_load_ctrl.sv
// Hardware boot sequencer: once HD/IM/DM report ready, copies BOOT_WORDS words
// from HD into IM one at a time and holds the CPU until the copy completes.
module boot_load_ctrl #(
  parameter int ADDR_W     = 26,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int BOOT_WORDS = 500,
  parameter int HD_BASE    = 0,
  parameter int IM_BASE    = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              hd_ready,
  input  logic              im_ready,
  input  logic              dm_ready,
  output logic              hd_rd,
  output logic [ADDR_W-1:0] hd_addr,
  input  logic              hd_valid,
  input  logic [DATA_W-1:0] hd_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_loaded
);

  typedef enum logic [2:0] {
    st_idle, st_check, st_req, st_wait, st_write, st_done, st_error
  } state_t;

  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BOOT_WORDS - 1);
  localparam logic [7:0]        TMO_MAX  = 8'(TIMEOUT);
  localparam logic [ADDR_W-1:0] HD_B     = ADDR_W'(HD_BASE);
  localparam logic [ADDR_W-1:0] IM_B     = ADDR_W'(IM_BASE);

  state_t           state, state_nx;
  logic [CNT_W-1:0] idx, idx_nx;
  logic [7:0]       tmo;
  logic             all_rdy, tmo_hit, last;

  assign all_rdy = hd_ready & im_ready & dm_ready;
  assign tmo_hit = (tmo == TMO_MAX);
  assign last    = (idx == LAST_IDX);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    hd_rd    = 1'b0;
    im_we    = 1'b0;
    unique case (state)
      st_idle, st_done, st_error: begin
        if (start) begin
          state_nx = st_check;
          idx_nx   = '0;
        end
      end
      st_check: begin
        if (all_rdy)      state_nx = st_req;
        else if (tmo_hit) state_nx = st_error;
      end
      st_req: begin
        hd_rd    = 1'b1;
        state_nx = st_wait;
      end
      st_wait: begin
        if (hd_valid)     state_nx = st_write;
        else if (tmo_hit) state_nx = st_error;
      end
      st_write: begin
        if (im_ready) begin
          im_we    = 1'b1;
          idx_nx   = idx + 1'b1;
          state_nx = last ? st_done : st_req;
        end else if (tmo_hit) begin
          state_nx = st_error;
        end
      end
      default: state_nx = st_idle;
    endcase
  end

  // tmo restarts on every state change, so each waiting state gets a full budget
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= st_idle;
      idx     <= '0;
      tmo     <= '0;
      hd_addr <= '0;
      im_addr <= '0;
      im_data <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (state_nx != state)
        tmo <= '0;
      else if (state == st_check || state == st_wait || state == st_write)
        tmo <= tmo + 8'd1;
      if (state_nx == st_req)
        hd_addr <= HD_B + ADDR_W'(idx_nx);
      if (state == st_wait && hd_valid) begin
        im_data <= hd_data;
        im_addr <= IM_B + ADDR_W'(idx);
      end
    end
  end

  assign busy         = (state == st_check) || (state == st_req) ||
                        (state == st_wait)  || (state == st_write);
  assign done         = (state == st_done);
  assign error        = (state == st_error);
  assign cpu_hold     = (state != st_done);
  assign words_loaded = idx;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Bench for boot_load_ctrl: an HD responder with configurable latency feeds the
// DUT, IM writes are scoreboarded and completion timing is derived from the protocol.
`timescale 1ns/1ps
module tb_boot_load_ctrl;
  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int NW     = 4;
  localparam int TMO    = 255;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              hd_ready = 1'b1, im_ready = 1'b1, dm_ready = 1'b1;
  logic              hd_valid = 1'b0;
  logic [DATA_W-1:0] hd_data = '0;
  logic              hd_rd, im_we, cpu_hold, busy, done, error;
  logic [ADDR_W-1:0] hd_addr, im_addr;
  logic [DATA_W-1:0] im_data;
  logic [CNT_W-1:0]  words_loaded;

  boot_load_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .BOOT_WORDS(NW),
    .HD_BASE(0), .IM_BASE(0), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .hd_ready(hd_ready), .im_ready(im_ready), .dm_ready(dm_ready),
    .hd_rd(hd_rd), .hd_addr(hd_addr), .hd_valid(hd_valid), .hd_data(hd_data),
    .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [DATA_W-1:0] hd_mem [0:63];

  // responder configuration and state
  int lat_fix, lat_rand, drop_from, stall_word, stall_len, stall_cnt;
  int pend_addr[$], pend_due[$], pend_word[$];
  int lat_used[$];
  // observations
  int                wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int                rd_addr[$];
  int done_cyc, err_cyc, first_rd_cyc;
  bit both_seen;

  task automatic begin_run(input int lf, input int lr, input int df, input int sw, input int sl);
    lat_fix = lf; lat_rand = lr; drop_from = df; stall_word = sw; stall_len = sl;
    stall_cnt = 0;
    pend_addr.delete(); pend_due.delete(); pend_word.delete(); lat_used.delete();
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
    done_cyc = -1; err_cyc = -1; first_rd_cyc = -1; both_seen = 0;
  endtask

  // one clock: observe outputs at the falling edge, then drive inputs for the next rise
  task automatic tick();
    int k, l;
    @(negedge clock);
    cyc++;
    if (stall_cnt > 0) begin im_ready = 1'b0; stall_cnt--; end
    else im_ready = 1'b1;
    if (im_we) begin
      wr_addr.push_back(int'(im_addr));
      wr_data.push_back(im_data);
    end
    if (hd_rd) begin
      k = rd_addr.size();
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      rd_addr.push_back(int'(hd_addr));
      if (k < drop_from) begin
        l = (lat_rand != 0) ? int'($urandom_range(1, 4)) : lat_fix;
        lat_used.push_back(l);
        pend_addr.push_back(int'(hd_addr));
        pend_due.push_back(cyc + l);
        pend_word.push_back(k);
      end
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    if (error && err_cyc < 0) err_cyc = cyc;
    if (done && error) both_seen = 1;
    hd_valid = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      hd_valid = 1'b1;
      hd_data  = hd_mem[pend_addr[0] & 63];
      if (pend_word[0] == stall_word) stall_cnt = stall_len;
      void'(pend_addr.pop_front()); void'(pend_due.pop_front()); void'(pend_word.pop_front());
    end
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string tag);
    for (int i = 0; i < budget && done_cyc < 0 && err_cyc < 0; i++) tick();
    n_cmp++;
    if (done_cyc < 0 && err_cyc < 0) begin
      n_bad++;
      $display("FAIL %s_end: no done/error within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    int s;
    begin_run(1, 0, 99, 99, 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({hd_rd, im_we, busy, done, error, cpu_hold} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b want 000001", {hd_rd, im_we, busy, done, error, cpu_hold});
    end
    n_cmp++;
    if (hd_addr !== '0 || im_addr !== '0 || im_data !== '0 || words_loaded !== '0) begin
      n_bad++;
      $display("FAIL reset_data got hd_addr=%0h im_addr=%0h im_data=%0h wl=%0d want all 0",
               hd_addr, im_addr, im_data, words_loaded);
    end
    reset = 1'b1;
    tick();
    // abort mid-WAIT of word 2 (HD never answers it)
    for (int a = 0; a < 64; a++) hd_mem[a] = 32'hA0 + a;
    begin_run(1, 0, 2, 99, 0);
    pulse_start(s);
    for (int i = 0; i < 100 && rd_addr.size() < 3; i++) tick();
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b1 || words_loaded !== 16'd2 || im_data !== 32'hA1) begin
      n_bad++;
      $display("FAIL pre_reset got busy=%b wl=%0d im_data=%0h want 1/2/a1", busy, words_loaded, im_data);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++;
    if ({hd_rd, im_we, busy, done, error, cpu_hold} !== 6'b000001 || hd_addr !== '0 ||
        im_addr !== '0 || im_data !== '0 || words_loaded !== '0) begin
      n_bad++;
      $display("FAIL reset_midwait got ctrl=%b hd_addr=%0h im_addr=%0h im_data=%0h wl=%0d want 000001/0/0/0/0",
               {hd_rd, im_we, busy, done, error, cpu_hold}, hd_addr, im_addr, im_data, words_loaded);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    int s;
    for (int a = 0; a < 64; a++) hd_mem[a] = 32'hA0 + a;
    begin_run(1, 0, 99, 99, 0);
    pulse_start(s);
    wait_end(200, "nominal");
    // 13 edges after the start edge; visible at the following falling edge
    n_cmp++;
    if (done_cyc != s + 14) begin
      n_bad++; $display("FAIL nominal_done_time got %0d want %0d", done_cyc - s, 14);
    end
    n_cmp++;
    if (wr_addr.size() != NW || rd_addr.size() != NW) begin
      n_bad++; $display("FAIL nominal_count got wr=%0d rd=%0d want %0d", wr_addr.size(), rd_addr.size(), NW);
    end
    for (int k = 0; k < NW && k < wr_addr.size() && k < rd_addr.size(); k++) begin
      n_cmp++;
      if (wr_addr[k] != k || wr_data[k] !== 32'hA0 + k || rd_addr[k] != k) begin
        n_bad++;
        $display("FAIL nominal_word%0d got im(%0h,%0h) hd %0h want im(%0h,%0h) hd %0h",
                 k, wr_addr[k], wr_data[k], rd_addr[k], k, 32'hA0 + k, k);
      end
    end
    n_cmp++;
    if ({done, error, cpu_hold, busy} !== 4'b1000 || words_loaded !== 16'(NW)) begin
      n_bad++;
      $display("FAIL nominal_final got d/e/h/b=%b wl=%0d want 1000 wl=%0d",
               {done, error, cpu_hold, busy}, words_loaded, NW);
    end
  endtask

  task automatic test_ready_stall();
    int s, exp;
    for (int a = 0; a < 64; a++) hd_mem[a] = $urandom;
    begin_run(1, 0, 99, 99, 0);
    dm_ready = 1'b0;
    pulse_start(s);
    repeat (9) tick();
    n_cmp++;
    if (first_rd_cyc >= 0) begin
      n_bad++; $display("FAIL stall_early_rd got rd at +%0d want none before +11", first_rd_cyc - s);
    end
    dm_ready = 1'b1;
    wait_end(200, "stall");
    n_cmp++;
    if (first_rd_cyc != s + 11) begin
      n_bad++; $display("FAIL stall_first_rd got +%0d want +11", first_rd_cyc - s);
    end
    exp = s + 11 + 3 * NW;
    n_cmp++;
    if (done_cyc != exp) begin
      n_bad++; $display("FAIL stall_done_time got +%0d want +%0d", done_cyc - s, exp - s);
    end
    n_cmp++;
    if (wr_addr.size() != NW || wr_data[NW-1] !== hd_mem[NW-1]) begin
      n_bad++; $display("FAIL stall_writes got %0d writes want %0d", wr_addr.size(), NW);
    end
  endtask

  task automatic test_timeout();
    int s;
    begin_run(1, 0, 0, 99, 0);
    pulse_start(s);
    wait_end(400, "timeout");
    n_cmp++;
    if (err_cyc != s + 3 + TMO + 1) begin
      n_bad++; $display("FAIL timeout_time got +%0d want +%0d", err_cyc - s, 3 + TMO + 1);
    end
    n_cmp++;
    if ({done, error, cpu_hold, busy} !== 4'b0110 || words_loaded !== '0 || wr_addr.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_state got d/e/h/b=%b wl=%0d writes=%0d want 0110 0 0",
               {done, error, cpu_hold, busy}, words_loaded, wr_addr.size());
    end
    for (int a = 0; a < 64; a++) hd_mem[a] = $urandom;
    begin_run(1, 0, 99, 99, 0);
    pulse_start(s);
    wait_end(200, "recover");
    n_cmp++;
    if (done_cyc != s + 14 || error !== 1'b0 || words_loaded !== 16'(NW) || wr_addr.size() != NW) begin
      n_bad++;
      $display("FAIL recover got done@+%0d err=%b wl=%0d writes=%0d want +14 0 %0d %0d",
               done_cyc - s, error, words_loaded, wr_addr.size(), NW, NW);
    end
  endtask

  task automatic test_backpressure();
    int s;
    for (int a = 0; a < 64; a++) hd_mem[a] = $urandom;
    begin_run(1, 0, 99, 2, 3);
    pulse_start(s);
    wait_end(200, "bp");
    n_cmp++;
    if (done_cyc != s + 14 + 3) begin
      n_bad++; $display("FAIL bp_done_time got +%0d want +17", done_cyc - s);
    end
    n_cmp++;
    if (wr_addr.size() != NW) begin
      n_bad++; $display("FAIL bp_count got %0d want %0d", wr_addr.size(), NW);
    end
    for (int k = 0; k < NW && k < wr_addr.size(); k++) begin
      n_cmp++;
      if (wr_addr[k] != k || wr_data[k] !== hd_mem[k]) begin
        n_bad++;
        $display("FAIL bp_word%0d got (%0h,%0h) want (%0h,%0h)", k, wr_addr[k], wr_data[k], k, hd_mem[k]);
      end
    end
  endtask

  task automatic test_start_busy();
    int s;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    begin_run(1, 0, 99, 99, 0);
    for (int i = 0; i < 3; i++) begin
      hd_valid = 1'b1;
      hd_data  = $urandom | 32'h1;
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0 || im_data !== '0 || rd_addr.size() != 0 || wr_addr.size() != 0) begin
      n_bad++;
      $display("FAIL spurious_valid got busy=%b im_data=%0h rd=%0d wr=%0d want 0 0 0 0",
               busy, im_data, rd_addr.size(), wr_addr.size());
    end
    for (int a = 0; a < 64; a++) hd_mem[a] = $urandom;
    begin_run(1, 0, 99, 99, 0);
    pulse_start(s);
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_end(200, "busy_start");
    n_cmp++;
    if (done_cyc != s + 14 || wr_addr.size() != NW || rd_addr.size() != NW) begin
      n_bad++;
      $display("FAIL start_while_busy got done@+%0d wr=%0d rd=%0d want +14 %0d %0d",
               done_cyc - s, wr_addr.size(), rd_addr.size(), NW, NW);
    end
  endtask

  // restarts straight from DONE with random latency, backpressure and ready stalls
  task automatic test_back_to_back();
    int s, d, sw, sl, exp;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 64; a++) hd_mem[a] = $urandom;
      sw = $urandom_range(0, NW);
      sl = $urandom_range(1, 4);
      d  = $urandom_range(0, 3);
      begin_run(1, 1, 99, sw, sl);
      dm_ready = (d > 0) ? 1'b0 : 1'b1;
      pulse_start(s);
      if (d > 0) begin
        repeat (d - 1) tick();
        dm_ready = 1'b1;
      end
      wait_end(300, "b2b");
      exp = s + 2 + ((d > 1) ? d - 1 : 0) + ((sw < NW) ? sl : 0);
      foreach (lat_used[k]) exp += 2 + lat_used[k];
      n_cmp++;
      if (done_cyc != exp || words_loaded !== 16'(NW) || both_seen) begin
        n_bad++;
        $display("FAIL b2b%0d_done got +%0d wl=%0d both=%0d want +%0d wl=%0d both=0",
                 it, done_cyc - s, words_loaded, both_seen, exp - s, NW);
      end
      n_cmp++;
      if (wr_addr.size() != NW) begin
        n_bad++; $display("FAIL b2b%0d_count got %0d want %0d", it, wr_addr.size(), NW);
      end
      for (int k = 0; k < NW && k < wr_addr.size(); k++) begin
        n_cmp++;
        if (wr_addr[k] != k || wr_data[k] !== hd_mem[k]) begin
          n_bad++;
          $display("FAIL b2b%0d_word%0d got (%0h,%0h) want (%0h,%0h)",
                   it, k, wr_addr[k], wr_data[k], k, hd_mem[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ready_stall();
    test_timeout();
    test_backpressure();
    test_start_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
